// File: rtl/counter_sequencer.sv
// counter_sequencer: two-port round-robin command sequencer for an 8-bit
// up/down/load counter. It accepts load / count-up-N / count-down-N commands
// from requesters A and B. Between commands it makes the counter reload its
// own value, and it reports the resulting count with a one-cycle done pulse.
module counter_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_arg,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_arg,
    output logic [1:0]       cnt_up_down,
    output logic [WIDTH-1:0] cnt_start_value,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] done_value,
    output logic             done_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [1:0] UD_DOWN = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_LOAD = 2'b10;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [1:0]       op_r_q;
    logic [WIDTH-1:0] arg_r_q;
    logic             id_r_q;
    logic [WIDTH-1:0] steps_left_q;
    logic             last_grant_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] done_value_q;
    logic             done_id_q;

    logic             grant_a;
    logic             grant_b;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_arg;
    logic             skip_exec;

    // Round-robin grant: only in IDLE and never while reset is asserted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            if (a_valid && b_valid) begin
                if (last_grant_q) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (a_valid) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end else begin
                grant_a = 1'b0;
                grant_b = 1'b0;
            end
        end else begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

    // Select the granted command. Reserved ops and zero-step counts skip EXEC.
    always_comb begin
        sel_op    = a_op;
        sel_arg   = a_arg;
        skip_exec = 1'b0;
        if (grant_b) begin
            sel_op  = b_op;
            sel_arg = b_arg;
        end else begin
            sel_op  = a_op;
            sel_arg = a_arg;
        end
        if (sel_op == OP_RSV) begin
            skip_exec = 1'b1;
        end else if (sel_op != OP_LOAD && sel_arg == {WIDTH{1'b0}}) begin
            skip_exec = 1'b1;
        end else begin
            skip_exec = 1'b0;
        end
    end

    // Counter drive. Outside EXEC the counter reloads its own registered value,
    // which is how it holds.
    always_comb begin
        cnt_up_down     = UD_LOAD;
        cnt_start_value = cnt_value;
        if (!rst && state_q == S_EXEC) begin
            case (op_r_q)
                OP_LOAD: cnt_start_value = arg_r_q;
                OP_UP:   cnt_up_down     = UD_UP;
                OP_DOWN: cnt_up_down     = UD_DOWN;
                default: cnt_up_down     = UD_LOAD;
            endcase
        end else begin
            cnt_up_down     = UD_LOAD;
            cnt_start_value = cnt_value;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_id    = done_id_q;
    // Show the live count during DONE. Otherwise hold the value captured then.
    assign done_value = done_q ? cnt_value : done_value_q;

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_r_q       <= 2'b00;
            arg_r_q      <= {WIDTH{1'b0}};
            id_r_q       <= 1'b0;
            steps_left_q <= {WIDTH{1'b0}};
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_value_q <= {WIDTH{1'b0}};
            done_id_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_a || grant_b) begin
                        op_r_q       <= sel_op;
                        arg_r_q      <= sel_arg;
                        id_r_q       <= grant_b;
                        steps_left_q <= sel_arg;
                        last_grant_q <= grant_b;
                        busy_q       <= 1'b1;
                        if (skip_exec) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            done_id_q <= grant_b;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    steps_left_q <= steps_left_q - ONE;
                    if (op_r_q == OP_LOAD || op_r_q == OP_RSV || steps_left_q <= ONE) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        done_id_q <= id_r_q;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    done_value_q <= cnt_value;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer, with a behavioural model of the counter.
module tb_counter_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [1:0]   a_op = 2'b00;
    logic [W-1:0] a_arg = 8'h00;
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [1:0]   b_op = 2'b00;
    logic [W-1:0] b_arg = 8'h00;
    logic [1:0]   cnt_up_down;
    logic [W-1:0] cnt_start_value;
    logic [W-1:0] cnt_value = 8'h00;
    logic         busy;
    logic         done;
    logic [W-1:0] done_value;
    logic         done_id;

    typedef struct {
        logic [7:0] val;
        logic       id;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   grant_log[$];
    int   acc_log[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   exec_cycles = 0;
    int   up_cycles = 0;
    int   dn_cycles = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter model: active-low reset tied to ~rst, 10 = load, 01 = up, 00 = down.
    always @(posedge clk) begin
        if (rst) cnt_value <= 8'h00;
        else begin
            case (cnt_up_down)
                2'b10:   cnt_value <= cnt_start_value;
                2'b01:   cnt_value <= cnt_value + 8'h01;
                2'b00:   cnt_value <= cnt_value - 8'h01;
                default: cnt_value <= cnt_value;
            endcase
        end
    end

    counter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_arg(a_arg),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_arg(b_arg),
        .cnt_up_down(cnt_up_down), .cnt_start_value(cnt_start_value),
        .cnt_value(cnt_value), .busy(busy), .done(done),
        .done_value(done_value), .done_id(done_id)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and tallies EXEC cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !done) exec_cycles++;
            if (cnt_up_down == 2'b01) up_cycles++;
            if (cnt_up_down == 2'b00) dn_cycles++;
            if (done) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got done_value 0x%0h expected no done (cycle %0d)", done_value, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_value", int'(done_value), int'(mon_e.val));
                    chk("done_id", int'(done_id), int'(mon_e.id));
                    chk("done_cycle", cyc, mon_e.cyc);
                    chk("busy_at_done", int'(busy), 1);
                end
            end
        end
    end

    task automatic send(input bit id, input logic [1:0] op, input logic [7:0] arg,
                        input logic [7:0] expv, input bit push);
        bit   got;
        int   lat;
        exp_t e;
        got = 1'b0;
        if (id == 1'b0) begin a_valid = 1'b1; a_op = op; a_arg = arg; end
        else            begin b_valid = 1'b1; b_op = op; b_arg = arg; end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if ((id == 1'b0 && a_ready) || (id == 1'b1 && b_ready)) begin
                got = 1'b1;
                break;
            end
        end
        chk("ready_seen", int'(got), 1);
        chk("single_ready", int'(a_ready && b_ready), 0);
        if (got) begin
            if (op == 2'b00) lat = 2;
            else if (op == 2'b11 || arg == 8'h00) lat = 1;
            else lat = int'(arg) + 1;
            grant_log.push_back(int'(id));
            acc_log.push_back(cyc);
            if (push) begin
                e.val = expv;
                e.id  = id;
                e.cyc = cyc + lat;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (id == 1'b0) a_valid = 1'b0;
        else            b_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: ready stays low even with both valids high, and the counter holds.
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", int'(a_ready), 0);
        chk("rst_b_ready", int'(b_ready), 0);
        chk("rst_up_down", int'(cnt_up_down), 2);
        chk("rst_start_value", int'(cnt_start_value), int'(cnt_value));
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_value", int'(done_value), 0);
        chk("rst_done_id", int'(done_id), 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Load 0x32, then hold it for 10 idle cycles.
        send(1'b0, 2'b00, 8'h32, 8'h32, 1'b1);
        drain();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_hold_value", int'(cnt_value), 8'h32);
            chk("idle_up_down", int'(cnt_up_down), 2);
        end

        // Count up 8, then B counts down 8.
        @(posedge clk); #1;
        up_cycles = 0;
        send(1'b0, 2'b01, 8'd8, 8'h3A, 1'b1);
        drain();
        chk("up8_exec_cycles", up_cycles, 8);
        dn_cycles = 0;
        send(1'b1, 2'b10, 8'd8, 8'h32, 1'b1);
        drain();
        chk("dn8_exec_cycles", dn_cycles, 8);

        // Wrap-around both ways, issued back to back.
        send(1'b0, 2'b00, 8'hFE, 8'hFE, 1'b1);
        send(1'b0, 2'b01, 8'd4, 8'h02, 1'b1);
        chk("load_spacing", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 3);
        drain();
        send(1'b0, 2'b00, 8'h01, 8'h01, 1'b1);
        send(1'b0, 2'b10, 8'd3, 8'hFE, 1'b1);
        drain();

        // Tie after reset: A first, then alternating grants.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        grant_log.delete();
        acc_log.delete();
        fork
            begin
                send(1'b0, 2'b00, 8'h11, 8'h11, 1'b1);
                send(1'b0, 2'b00, 8'h33, 8'h33, 1'b1);
            end
            begin
                send(1'b1, 2'b00, 8'h22, 8'h22, 1'b1);
                send(1'b1, 2'b00, 8'h44, 8'h44, 1'b1);
            end
        join
        drain();
        chk("grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("grant0", grant_log[0], 0);
            chk("grant1", grant_log[1], 1);
            chk("grant2", grant_log[2], 0);
            chk("grant3", grant_log[3], 1);
            chk("b_after_a_done", acc_log[1] - acc_log[0], 3);
        end

        // N = 0 and reserved op: done one cycle after accept, with no EXEC cycle.
        exec_cycles = 0;
        send(1'b0, 2'b01, 8'h00, 8'h44, 1'b1);
        drain();
        send(1'b1, 2'b11, 8'h05, 8'h44, 1'b1);
        drain();
        chk("no_exec_cycles", exec_cycles, 0);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Abort in the third EXEC cycle of an up-10 command.
        @(posedge clk); #1;
        send(1'b0, 2'b01, 8'd10, 8'h00, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cnt_value", int'(cnt_value), 0);
        chk("abort_up_down", int'(cnt_up_down), 2);
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        send(1'b0, 2'b00, 8'hC8, 8'hC8, 1'b1);
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
